// File: rtl/pipe_credit_drain_if.sv
// Handshake bundle around the drain stage: upstream credit, pipeline output tap, downstream ready/valid.
interface pipe_credit_drain_if #(
  parameter int M     = 3,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  pipe_out;
  logic [M-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, pipe_out, out_ready,
    output in_ready, out_data, out_valid, count
  );

  modport master (
    output in_valid, pipe_out, out_ready,
    input  in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/pipe_credit_drain.sv
// Credit-gated output FIFO for a fixed-latency, non-stallable M x N pipeline.
// Optional feature macro: PIPE_CREDIT_DRAIN_BYPASS_EN (empty-FIFO bypass, latency N instead of N+1).
module pipe_credit_drain #(
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_credit_drain_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(N + 1);

  logic [N-1:0]  r_vld;
  logic [IW-1:0] r_inflight;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [M-1:0]  r_mem [DEPTH];

  logic          w_accept;
  logic          w_vld_n;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;
  logic [M-1:0]  w_out_data;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;

  // Credits cover FIFO occupancy plus every beat still travelling the pipeline.
  assign bus.in_ready = (int'(r_count) + int'(r_inflight)) < DEPTH;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_vld_n      = r_vld[N-1];

`ifdef PIPE_CREDIT_DRAIN_BYPASS_EN
  always_comb begin
    w_out_valid = (r_count != '0) || w_vld_n;
    w_out_data  = '0;
    if (r_count != '0)
      w_out_data = r_mem[r_head];
    else if (w_vld_n)
      w_out_data = bus.pipe_out;
    w_bypass    = (r_count == '0) && w_vld_n && bus.out_ready;
  end
`else
  always_comb begin
    w_out_valid = (r_count != '0);
    w_out_data  = w_out_valid ? r_mem[r_head] : '0;
    w_bypass    = 1'b0;
  end
`endif

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.count     = r_count;

  assign w_push     = w_vld_n && !w_bypass;
  assign w_pop      = bus.out_ready && (r_count != '0);
  assign w_head_nxt = (r_head == PW'(DEPTH - 1)) ? '0 : r_head + PW'(1);
  assign w_tail_nxt = (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + PW'(1);

  // Control state: valid line, in-flight credits, occupancy and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_vld      <= (r_vld << 1) | N'(w_accept);
      r_inflight <= r_inflight + IW'(w_accept) - IW'(w_vld_n);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)
        r_head <= w_head_nxt;
      if (w_push)
        r_tail <= w_tail_nxt;
    end
  end

  // Storage is data-only and never needs clearing: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_tail] <= bus.pipe_out;
  end

  // Unreachable while N and DEPTH match the real pipeline; catches a mis-sized instance.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == CW'(DEPTH)) && !w_pop));

endmodule
